// File: rtl/y86_pkg.sv
// ----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86 execute stage.
//   alu_op_t : ALU control encodings (add, subtract, AND, XOR)
//   ALU_CTRL_W : width of the ALU control field
// ----------------------------------------------------------------------------
package y86_pkg;

    localparam int ALU_CTRL_W = 2;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

endpackage : y86_pkg

// File: rtl/y86_adder.sv
// ----------------------------------------------------------------------------
// y86_adder
// WIDTH-bit two's complement adder with carry-in.
//   a, b     : operands
//   cin      : carry into bit 0
//   sum      : a + b + cin, modulo 2^WIDTH
//   carry    : carry out of bit WIDTH-1
//   overflow : signed overflow (operands agree in sign, result does not)
// ----------------------------------------------------------------------------
module y86_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum      = full_sum[WIDTH-1:0];
        carry    = full_sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (full_sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule : y86_adder

// File: rtl/y86_alu.sv
// ----------------------------------------------------------------------------
// y86_alu
// Y86 execute-stage ALU with registered condition codes.
//   clock              : rising-edge clock
//   reset_n            : asynchronous active-low reset (clears zf/sf/of only)
//   en                 : when high, load condition codes on this edge
//   control            : 0 add, 1 subtract, 2 AND, 3 XOR
//   input1, input2     : two's complement operands
//   alu_out            : combinational result
//   alu_carry_out      : combinational carry (add) / borrow (sub), 0 for logic
//   alu_overflow_check : combinational signed overflow, 0 for logic
//   zf, sf, of         : registered zero / sign / overflow flags
// ----------------------------------------------------------------------------
module y86_alu
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [ALU_CTRL_W-1:0] control,
    input  logic [WIDTH-1:0]      input1,
    input  logic [WIDTH-1:0]      input2,
    output logic [WIDTH-1:0]      alu_out,
    output logic                  alu_carry_out,
    output logic                  alu_overflow_check,
    output logic                  zf,
    output logic                  sf,
    output logic                  of
);

    alu_op_t          op;
    logic             is_sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             add_ovf;

    assign op     = alu_op_t'(control);
    assign is_sub = (op == ALU_SUB);

    // Subtraction reuses the adder as input1 + ~input2 + 1.
    assign add_b  = is_sub ? ~input2 : input2;

    y86_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a        (input1),
        .b        (add_b),
        .cin      (is_sub),
        .sum      (add_sum),
        .carry    (add_carry),
        .overflow (add_ovf)
    );

    always_comb begin
        alu_out            = add_sum;
        alu_carry_out      = 1'b0;
        alu_overflow_check = 1'b0;
        case (op)
            ALU_ADD: begin
                alu_out            = add_sum;
                alu_carry_out      = add_carry;
                alu_overflow_check = add_ovf;
            end
            ALU_SUB: begin
                // Borrow is the inverse of the carry out of a + ~b + 1.
                alu_out            = add_sum;
                alu_carry_out      = ~add_carry;
                alu_overflow_check = add_ovf;
            end
            ALU_AND: alu_out = input1 & input2;
            ALU_XOR: alu_out = input1 ^ input2;
            default: alu_out = add_sum;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zf <= 1'b0;
            sf <= 1'b0;
            of <= 1'b0;
        end else if (en) begin
            zf <= (alu_out == '0);
            sf <= alu_out[WIDTH-1];
            of <= alu_overflow_check;
        end
    end

endmodule : y86_alu

// File: tb/tb_y86_alu.sv
// ----------------------------------------------------------------------------
// tb_y86_alu
// Scoreboard bench for y86_alu: each applied vector queues its expected
// combinational result and the expected flags after the following edge;
// two monitors pop and compare independently of the stimulus.
// ----------------------------------------------------------------------------
module tb_y86_alu;

    localparam int W = 64;
    localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clock;
    logic         reset_n;
    logic         en;
    logic [1:0]   control;
    logic [W-1:0] input1;
    logic [W-1:0] input2;
    logic [W-1:0] alu_out;
    logic         alu_carry_out;
    logic         alu_overflow_check;
    logic         zf;
    logic         sf;
    logic         of;

    typedef struct {
        int           id;
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } comb_exp_t;

    typedef struct {
        int   id;
        logic z;
        logic s;
        logic o;
    } flag_exp_t;

    comb_exp_t comb_q[$];
    flag_exp_t flag_q[$];

    logic vld;
    int   vec_id;
    int   n_checks;
    int   n_fail;

    y86_alu #(
        .WIDTH (W)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .en                 (en),
        .control            (control),
        .input1             (input1),
        .input2             (input2),
        .alu_out            (alu_out),
        .alu_carry_out      (alu_carry_out),
        .alu_overflow_check (alu_overflow_check),
        .zf                 (zf),
        .sf                 (sf),
        .of                 (of)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector 2 time units after a rising edge and queue its expectations.
    task automatic apply(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic e, input logic [W-1:0] eo, input logic ec, input logic ev,
                         input logic ez, input logic es, input logic eof);
        comb_exp_t ce;
        flag_exp_t fe;
        @(posedge clock);
        #2;
        vec_id++;
        control = c;
        input1  = a;
        input2  = b;
        en      = e;
        ce.id = vec_id; ce.res = eo; ce.c = ec; ce.v = ev;
        fe.id = vec_id; fe.z = ez; fe.s = es; fe.o = eof;
        comb_q.push_back(ce);
        flag_q.push_back(fe);
        vld = 1'b1;
    endtask

    task automatic idle();
        @(posedge clock);
        #2;
        vld = 1'b0;
        en  = 1'b0;
    endtask

    // Combinational monitor: results are stable by the falling edge.
    always @(negedge clock) begin
        if (vld) begin
            if (comb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL comb_q: result presented with no expectation queued");
            end else begin
                comb_exp_t ce;
                ce = comb_q.pop_front();
                check($sformatf("alu_out[v%0d]", ce.id), alu_out, ce.res);
                check($sformatf("carry[v%0d]", ce.id), {{(W-1){1'b0}}, alu_carry_out}, {{(W-1){1'b0}}, ce.c});
                check($sformatf("overflow[v%0d]", ce.id), {{(W-1){1'b0}}, alu_overflow_check}, {{(W-1){1'b0}}, ce.v});
            end
        end
    end

    // Flag monitor: flags for the vector applied last cycle, just after the edge.
    always @(posedge clock) begin
        #1;
        if (vld) begin
            if (flag_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL flag_q: flags presented with no expectation queued");
            end else begin
                flag_exp_t fe;
                fe = flag_q.pop_front();
                check($sformatf("zf[v%0d]", fe.id), {{(W-1){1'b0}}, zf}, {{(W-1){1'b0}}, fe.z});
                check($sformatf("sf[v%0d]", fe.id), {{(W-1){1'b0}}, sf}, {{(W-1){1'b0}}, fe.s});
                check($sformatf("of[v%0d]", fe.id), {{(W-1){1'b0}}, of}, {{(W-1){1'b0}}, fe.o});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vec_id   = 0;
        vld      = 1'b0;
        reset_n  = 1'b0;
        en       = 1'b0;
        control  = 2'd0;
        input1   = '0;
        input2   = '0;

        #1;
        check("reset_zf", {{(W-1){1'b0}}, zf}, '0);
        check("reset_sf", {{(W-1){1'b0}}, sf}, '0);
        check("reset_of", {{(W-1){1'b0}}, of}, '0);
        #12;
        reset_n = 1'b1;

        //     ctl   input1        input2        en  alu_out       c     v     zf    sf    of
        apply(2'd0, 64'd5,        64'd7,        1, 64'd12,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(2'd0, MAXP,         64'd1,        1, MINN,         1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        apply(2'd1, 64'h1234,     64'h1234,     1, 64'd0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(2'd1, 64'd0,        64'd1,        1, ONES,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(2'd2, 64'hF0F0,     64'h0FF0,     1, 64'h00F0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(2'd3, 64'hF0F0,     64'h0FF0,     1, 64'hFF00,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(2'd0, ONES,         64'd1,        1, 64'd0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(2'd1, MINN,         64'd1,        1, MAXP,         1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        apply(2'd3, ONES,         64'h0F,       1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Enable hold: zero result loaded, then nonzero results with en low.
        apply(2'd1, 64'h55,       64'h55,       1, 64'd0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(2'd0, 64'd3,        64'd4,        0, 64'd7,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(2'd1, 64'd0,        64'd1,        0, ONES,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(2'd0, MAXP,         64'd1,        0, MINN,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Load nonzero sf/of, then assert reset mid-cycle.
        apply(2'd0, MAXP,         64'd1,        1, MINN,         1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_zf", {{(W-1){1'b0}}, zf}, '0);
        check("async_reset_sf", {{(W-1){1'b0}}, sf}, '0);
        check("async_reset_of", {{(W-1){1'b0}}, of}, '0);

        // Flags stay cleared with en high; combinational path unaffected.
        apply(2'd0, MAXP,         64'd1,        1, MINN,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(2'd1, 64'd0,        64'd1,        1, ONES,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        #1;
        reset_n = 1'b1;

        apply(2'd1, 64'd0,        64'd1,        1, ONES,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();

        n_checks++;
        if (comb_q.size() != 0 || flag_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d entries left, expected 0/0", comb_q.size(), flag_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_y86_alu
